// File: rtl/sprite_pkg.sv
// Shared address map, per-channel register struct and colour helper for the
// sprite compositor.
package sprite_pkg;

    localparam logic [1:0] REG_X       = 2'd0;
    localparam logic [1:0] REG_Y       = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [8:0] ADDR_STATUS = 9'h1FF;

    // frame is stored already masked to the configured frame-select width
    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
        logic [7:0]  frame;
    } sprite_regs_t;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: active registers loaded at commit, hit compare,
// ROM address generation and the opaque flag aligned with the ROM data.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter logic [15:0] KEY_COLOR = 16'hF81F,
    parameter int          AW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_commit,
    input  logic [10:0]   i_x,
    input  logic [9:0]    i_y,
    input  logic          i_en,
    input  logic [7:0]    i_frame,
    input  logic [10:0]   i_hcount,
    input  logic [9:0]    i_vcount,
    input  logic [15:0]   i_rom_data,
    output logic [AW-1:0] o_rom_addr,
    output logic          o_opaque
);

    logic [10:0]   r_x;
    logic [9:0]    r_y;
    logic          r_en;
    logic [7:0]    r_frame;
    logic          r_hit;
    logic          r_hit_d;
    logic [AW-1:0] r_rom_addr;

    logic [11:0]   w_h;
    logic [11:0]   w_v;
    logic [11:0]   w_x;
    logic [11:0]   w_y;
    logic          w_hit;
    logic [10:0]   w_dx;
    logic [9:0]    w_dy;
    logic [AW-1:0] w_addr;

    // 12-bit compare so x+SPR_W near the right edge clips instead of wrapping
    assign w_h   = {1'b0, i_hcount};
    assign w_v   = {2'b00, i_vcount};
    assign w_x   = {1'b0, r_x};
    assign w_y   = {2'b00, r_y};
    assign w_hit = r_en && (w_h >= w_x) && (w_h < w_x + 12'(SPR_W))
                        && (w_v >= w_y) && (w_v < w_y + 12'(SPR_H));

    assign w_dx   = i_hcount - r_x;
    assign w_dy   = i_vcount - r_y;
    assign w_addr = AW'(r_frame) * AW'(SPR_W * SPR_H) + AW'(w_dy) * AW'(SPR_W) + AW'(w_dx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_en       <= 1'b0;
            r_frame    <= '0;
            r_hit      <= 1'b0;
            r_hit_d    <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            if (i_commit) begin
                r_x     <= i_x;
                r_y     <= i_y;
                r_en    <= i_en;
                r_frame <= i_frame;
            end
            r_hit   <= w_hit;
            r_hit_d <= r_hit;
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    assign o_rom_addr = r_rom_addr;
    // r_hit_d lines up with the ROM word fetched from the address registered with r_hit
    assign o_opaque   = r_hit_d && (i_rom_data != KEY_COLOR);

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: Avalon-MM register file with frame commit,
// fixed-priority transparency mux. Define SPRITE_COLLISION_EN for the status register.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int          N_SPRITES = 8,
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter int          FRAMES    = 4,
    parameter logic [15:0] KEY_COLOR = 16'hF81F,
    parameter logic [23:0] BG_COLOR  = 24'hFFFFFF,
    parameter int          HACTIVE   = 1280,
    parameter int          VACTIVE   = 480,
    localparam int         AW        = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    read,
    input  logic [8:0]              address,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    input  logic                    blank_n_in,
    output logic [N_SPRITES*AW-1:0] rom_addr,
    input  logic [N_SPRITES*16-1:0] rom_data,
    output logic [23:0]             rgb,
    output logic                    blank_n_out
);

    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    sprite_regs_t         r_shadow [N_SPRITES];
    logic [31:0]          r_readdata;
    logic                 r_blank_d1;
    logic                 r_blank_d2;
    logic [23:0]          r_rgb;
    logic                 r_blank_out;

    logic [6:0]           w_ch;
    logic [1:0]           w_reg;
    logic                 w_commit;
    logic [31:0]          w_rdata;
    logic [N_SPRITES-1:0] w_opaque;
    logic [23:0]          w_pix;
    logic                 w_unused;

    assign w_ch     = address[8:2];
    assign w_reg    = address[1:0];
    assign w_commit = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    assign w_unused = ^{writedata[31:11], 11'(HACTIVE)};

    // Shadow writes; a write in the commit cycle lands after the copy to active
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (chipselect && write) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (w_ch == 7'(i)) begin
                    case (w_reg)
                        REG_X:    r_shadow[i].x <= writedata[10:0];
                        REG_Y:    r_shadow[i].y <= writedata[9:0];
                        REG_CTRL: begin
                            r_shadow[i].en    <= writedata[0];
                            r_shadow[i].frame <= 8'(writedata[FW:1]);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic [N_SPRITES-1:0] r_pending;
    logic [N_SPRITES-1:0] r_status;
    logic                 w_collide;

    assign w_collide = (w_opaque & (w_opaque - 1'b1)) != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_status  <= '0;
        end else if (w_commit) begin
            r_status  <= r_pending;
            r_pending <= w_collide ? w_opaque : '0;
        end else if (w_collide) begin
            r_pending <= r_pending | w_opaque;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (w_ch == 7'(i)) begin
                case (w_reg)
                    REG_X:    w_rdata = 32'(r_shadow[i].x);
                    REG_Y:    w_rdata = 32'(r_shadow[i].y);
                    REG_CTRL: w_rdata = 32'({r_shadow[i].frame[FW-1:0], r_shadow[i].en});
                    default:  w_rdata = '0;
                endcase
            end
        end
`ifdef SPRITE_COLLISION_EN
        if (address == ADDR_STATUS) begin
            w_rdata = 32'(r_status);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (chipselect && read) begin
            r_readdata <= w_rdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_SPRITES; g++) begin : g_chan
            sprite_channel #(
                .SPR_W     (SPR_W),
                .SPR_H     (SPR_H),
                .KEY_COLOR (KEY_COLOR),
                .AW        (AW)
            ) u_chan (
                .clk        (clk),
                .rst        (reset),
                .i_commit   (w_commit),
                .i_x        (r_shadow[g].x),
                .i_y        (r_shadow[g].y),
                .i_en       (r_shadow[g].en),
                .i_frame    (r_shadow[g].frame),
                .i_hcount   (hcount),
                .i_vcount   (vcount),
                .i_rom_data (rom_data[g*16 +: 16]),
                .o_rom_addr (rom_addr[g*AW +: AW]),
                .o_opaque   (w_opaque[g])
            );
        end
    endgenerate

    // Walk from lowest priority up so channel 0 overrides everything
    always_comb begin
        w_pix = BG_COLOR;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (w_opaque[i]) begin
                w_pix = rgb565_to_888(rom_data[i*16 +: 16]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank_d1  <= 1'b0;
            r_blank_d2  <= 1'b0;
            r_rgb       <= '0;
            r_blank_out <= 1'b0;
        end else begin
            r_blank_d1  <= blank_n_in;
            r_blank_d2  <= r_blank_d1;
            r_rgb       <= r_blank_d2 ? w_pix : 24'd0;
            r_blank_out <= r_blank_d2;
        end
    end

    assign readdata    = r_readdata;
    assign rgb         = r_rgb;
    assign blank_n_out = r_blank_out;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: a pixel-level reference model
// predicts {blank_n_out, rgb}, register reads and the collision status.
`timescale 1ns/1ps
module tb_sprite_compositor;

    localparam int          N    = 8;
    localparam int          AW   = 12;
    localparam logic [15:0] KEY  = 16'hF81F;
    localparam logic [23:0] BG   = 24'hFFFFFF;
    localparam int          VACT = 480;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            chipselect = 1'b0;
    logic            write = 1'b0;
    logic            read = 1'b0;
    logic [8:0]      address = '0;
    logic [31:0]     writedata = '0;
    logic [31:0]     readdata;
    logic [10:0]     hcount = '0;
    logic [9:0]      vcount = '0;
    logic            blank_n_in = 1'b0;
    logic [N*AW-1:0] rom_addr;
    logic [N*16-1:0] rom_data;
    logic [23:0]     rgb;
    logic            blank_n_out;

    sprite_compositor dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n_in  (blank_n_in),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rgb         (rgb),
        .blank_n_out (blank_n_out)
    );

    always #5 clk = ~clk;

    // Sprite ROMs with one-cycle synchronous read
    logic [15:0] rom_mem [N][4096];
    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            rom_data[c*16 +: 16] <= rom_mem[c][rom_addr[c*AW +: AW]];
        end
    end

    // Reference model state
    int          m_sx [N];
    int          m_sy [N];
    int          m_sen [N];
    int          m_sfr [N];
    int          m_ax [N];
    int          m_ay [N];
    int          m_aen [N];
    int          m_afr [N];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_stat;
    logic [24:0]  exp_q [$];
    logic [N-1:0] opq_q [$];
    int           pos_q [$];
    int           n_checks;
    int           n_fail;

    function automatic logic [23:0] to888(input logic [15:0] c);
        int r, g, b;
        r = int'(c) / 2048;
        g = (int'(c) / 32) % 64;
        b = int'(c) % 32;
        return 24'((r * 8) * 65536 + (g * 4) * 256 + b * 8);
    endfunction

    function automatic void model_pixel(input int h, input int v, input bit b,
                                        output logic [24:0] e, output logic [N-1:0] o);
        logic [23:0] col;
        bit          found;
        col   = BG;
        found = 0;
        o     = '0;
        for (int c = 0; c < N; c++) begin
            if (m_aen[c] != 0 && h >= m_ax[c] && h < m_ax[c] + 32 &&
                v >= m_ay[c] && v < m_ay[c] + 32) begin
                int          a;
                logic [15:0] d;
                a = m_afr[c] * 1024 + (v - m_ay[c]) * 32 + (h - m_ax[c]);
                d = rom_mem[c][a];
                if (d != KEY) begin
                    o[c] = 1'b1;
                    if (!found) begin
                        col   = to888(d);
                        found = 1;
                    end
                end
            end
        end
        e = b ? {1'b1, col} : 25'd0;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d);
        int c, r;
        c = a / 4;
        r = a % 4;
        if (c < N) begin
            case (r)
                0: m_sx[c] = int'(d[10:0]);
                1: m_sy[c] = int'(d[9:0]);
                2: begin
                    m_sen[c] = int'(d[0]);
                    m_sfr[c] = int'(d[2:1]);
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        int c, r;
        c = a / 4;
        r = a % 4;
        if (a == 511) begin
`ifdef SPRITE_COLLISION_EN
            return 32'(m_stat);
`else
            return 32'd0;
`endif
        end
        if (c >= N) return 32'd0;
        case (r)
            0:       return 32'(m_sx[c]);
            1:       return 32'(m_sy[c]);
            2:       return 32'(m_sfr[c] * 2 + m_sen[c]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_sx[c] = 0; m_sy[c] = 0; m_sen[c] = 0; m_sfr[c] = 0;
            m_ax[c] = 0; m_ay[c] = 0; m_aen[c] = 0; m_afr[c] = 0;
        end
        m_pend = '0;
        m_stat = '0;
        exp_q.delete();
        opq_q.delete();
        pos_q.delete();
        // two pipeline slots hold reset contents before the first real pixel
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(25'd0);
            opq_q.push_back('0);
            pos_q.push_back(-1);
        end
    endfunction

    // Driver: one pixel per clock plus whatever bus strobes the caller set up
    task automatic cycle(input int h, input int v, input bit b);
        logic [24:0]  e;
        logic [N-1:0] o;
        bit           commit;
        int           p;
        hcount     = 11'(h);
        vcount     = 10'(v);
        blank_n_in = b;
        model_pixel(h, v, b, e, o);
        exp_q.push_back(e);
        opq_q.push_back(o);
        pos_q.push_back(h * 1024 + v);
        commit = (h == 0 && v == VACT);
        @(posedge clk);
        #1;
        if (commit) begin
            for (int c = 0; c < N; c++) begin
                m_ax[c] = m_sx[c]; m_ay[c] = m_sy[c];
                m_aen[c] = m_sen[c]; m_afr[c] = m_sfr[c];
            end
        end
        if (chipselect && write) model_write(int'(address), writedata);
        chipselect = 1'b0;
        write      = 1'b0;
        read       = 1'b0;
        e = exp_q.pop_front();
        o = opq_q.pop_front();
        p = pos_q.pop_front();
        if (commit) begin
            m_stat = m_pend;
            m_pend = ($countones(o) >= 2) ? o : '0;
        end else if ($countones(o) >= 2) begin
            m_pend = m_pend | o;
        end
        n_checks++;
        if ({blank_n_out, rgb} !== e) begin
            n_fail++;
            $display("FAIL pixel h=%0d v=%0d: got blank=%b rgb=%h, expected blank=%b rgb=%h",
                     p / 1024, p % 1024, blank_n_out, rgb, e[24], e[23:0]);
        end
    endtask

    task automatic bus_write(input int a, input int d, input int h, input int v, input bit b);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = 9'(a);
        writedata  = 32'(d);
        cycle(h, v, b);
    endtask

    task automatic bus_read(input int a, input int h, input int v, input bit b,
                            output logic [31:0] got);
        logic [31:0] exp;
        exp        = model_read(a);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = 9'(a);
        cycle(h, v, b);
        got = readdata;
        n_checks++;
        if (readdata !== exp) begin
            n_fail++;
            $display("FAIL read addr=%h: got %h expected %h", a, readdata, exp);
        end
    endtask

    task automatic draw_line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) cycle(h, v, (h < 1280 && v < 480));
    endtask

    task automatic commit_frame();
        cycle(0, VACT, 1'b0);
    endtask

    task automatic fill_rom();
        for (int c = 0; c < N; c++) begin
            for (int a = 0; a < 4096; a++) begin
                logic [15:0] d;
                d = 16'($urandom);
                if ($urandom_range(0, 7) == 0) d = KEY;
                if ((c == 2 || c == 5) && d == KEY) d = 16'h0001;
                rom_mem[c][a] = d;
            end
        end
        rom_mem[0][1024] = 16'h001F;
        rom_mem[0][0]    = KEY;
        rom_mem[0][1]    = 16'h1234;
        rom_mem[1][0]    = 16'h07E0;
        rom_mem[1][1]    = 16'hABCD;
        rom_mem[3][9]    = 16'h8000;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (rgb !== 24'd0 || blank_n_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pixel: got rgb=%h blank=%b expected 0/0", rgb, blank_n_out);
        end
        n_checks++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %h expected 0", readdata);
        end
        n_checks++;
        if (rom_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(5, 5, 1);
        cycle(6, 5, 1);
        cycle(7, 5, 1);
        n_checks++;
        if (rgb !== BG || blank_n_out !== 1'b1) begin
            n_fail++;
            $display("FAIL first_pixel: got rgb=%h blank=%b expected %h/1", rgb, blank_n_out, BG);
        end
    endtask

    task automatic test_basic();
        logic [31:0] got;
        bus_write(2, 3, 0, 520, 0);
        bus_write(0, 100, 0, 520, 0);
        bus_write(1, 100, 0, 520, 0);
        bus_read(0, 0, 520, 0, got);
        bus_read(1, 0, 520, 0, got);
        bus_read(2, 0, 520, 0, got);
        n_checks++;
        if (got !== 32'd3) begin
            n_fail++;
            $display("FAIL ctrl_readback: got %h expected 3", got);
        end
        commit_frame();
        for (int h = 96; h <= 135; h++) begin
            cycle(h, 100, 1);
            if (h == 100) begin
                n_checks++;
                if (rom_addr[AW-1:0] !== 12'd1024) begin
                    n_fail++;
                    $display("FAIL rom_addr0_at_100: got %0d expected 1024", rom_addr[AW-1:0]);
                end
            end
            if (h == 102) begin
                n_checks++;
                if (rgb !== 24'h0000F8) begin
                    n_fail++;
                    $display("FAIL pixel_100_100: got %h expected 0000f8", rgb);
                end
            end
        end
        draw_line(131, 96, 135);
        draw_line(132, 96, 104);
    endtask

    task automatic test_shadow_commit();
        logic [31:0] got;
        for (int h = 96; h <= 140; h++) begin
            if (h == 97) bus_write(0, 110, h, 100, 1);
            else cycle(h, 100, 1);
            if (h == 100) begin
                n_checks++;
                if (rom_addr[AW-1:0] !== 12'd1024) begin
                    n_fail++;
                    $display("FAIL shadow_no_move: got %0d expected 1024", rom_addr[AW-1:0]);
                end
            end
        end
        bus_read(0, 0, 520, 0, got);
        commit_frame();
        draw_line(100, 96, 150);
        cycle(110, 100, 1);
        n_checks++;
        if (rom_addr[AW-1:0] !== 12'd1024) begin
            n_fail++;
            $display("FAIL moved_to_110: got %0d expected 1024", rom_addr[AW-1:0]);
        end
        // write coinciding with the commit pixel only reaches the shadow
        bus_write(0, 120, 0, VACT, 0);
        bus_read(0, 0, 520, 0, got);
        n_checks++;
        if (got !== 32'd120) begin
            n_fail++;
            $display("FAIL shadow_x_readback: got %0d expected 120", got);
        end
        draw_line(100, 105, 125);
        cycle(110, 100, 1);
        n_checks++;
        if (rom_addr[AW-1:0] !== 12'd1024) begin
            n_fail++;
            $display("FAIL commit_cycle_write_late: got %0d expected 1024", rom_addr[AW-1:0]);
        end
        commit_frame();
        draw_line(100, 110, 160);
        cycle(120, 100, 1);
        n_checks++;
        if (rom_addr[AW-1:0] !== 12'd1024) begin
            n_fail++;
            $display("FAIL moved_to_120: got %0d expected 1024", rom_addr[AW-1:0]);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] got;
        bus_write(3, 32'h1234, 0, 520, 0);
        bus_read(3, 0, 520, 0, got);
        n_checks++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL reserved_read: got %h expected 0", got);
        end
        bus_write(100, 32'h55, 0, 520, 0);
        bus_read(100, 0, 520, 0, got);
        n_checks++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h expected 0", got);
        end
    endtask

    task automatic test_priority();
        bus_write(0, 200, 0, 520, 0);
        bus_write(1, 50, 0, 520, 0);
        bus_write(2, 1, 0, 520, 0);
        bus_write(4, 200, 0, 520, 0);
        bus_write(5, 50, 0, 520, 0);
        bus_write(6, 1, 0, 520, 0);
        commit_frame();
        for (int h = 196; h <= 240; h++) begin
            cycle(h, 50, 1);
            if (h == 202) begin
                n_checks++;
                if (rgb !== 24'h00FC00) begin
                    n_fail++;
                    $display("FAIL prio_ch0_key: got %h expected 00fc00", rgb);
                end
            end
            if (h == 203) begin
                n_checks++;
                if (rgb !== 24'h1044A0) begin
                    n_fail++;
                    $display("FAIL prio_ch0_wins: got %h expected 1044a0", rgb);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] got;
        logic [31:0] want;
        bus_write(2, 0, 0, 520, 0);
        bus_write(6, 0, 0, 520, 0);
        bus_write(8, 300, 0, 520, 0);
        bus_write(9, 200, 0, 520, 0);
        bus_write(10, 1, 0, 520, 0);
        bus_write(20, 310, 0, 520, 0);
        bus_write(21, 210, 0, 520, 0);
        bus_write(22, 1, 0, 520, 0);
        commit_frame();
        bus_read(511, 0, 520, 0, got);
        commit_frame();
        draw_line(215, 296, 345);
        commit_frame();
        bus_read(511, 0, 520, 0, got);
`ifdef SPRITE_COLLISION_EN
        want = 32'h24;
`else
        want = 32'h0;
`endif
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL collision_status: got %h expected %h", got, want);
        end
        draw_line(100, 296, 345);
        commit_frame();
        bus_read(511, 0, 520, 0, got);
        n_checks++;
        if (got !== 32'h0) begin
            n_fail++;
            $display("FAIL collision_cleared: got %h expected 0", got);
        end
    endtask

    task automatic test_right_edge();
        bus_write(10, 0, 0, 520, 0);
        bus_write(22, 0, 0, 520, 0);
        bus_write(12, 1270, 0, 520, 0);
        bus_write(13, 10, 0, 520, 0);
        bus_write(14, 1, 0, 520, 0);
        commit_frame();
        for (int h = 1262; h <= 1295; h++) begin
            cycle(h, 10, (h < 1280));
            if (h == 1281) begin
                n_checks++;
                if (rgb !== 24'h800000) begin
                    n_fail++;
                    $display("FAIL edge_col_1279: got %h expected 800000", rgb);
                end
            end
            if (h == 1290) begin
                n_checks++;
                if (rgb !== 24'd0 || blank_n_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL blank_black: got rgb=%h blank=%b expected 0/0", rgb, blank_n_out);
                end
            end
        end
        for (int h = 0; h <= 8; h++) begin
            cycle(h, 10, 1);
            if (h == 2) begin
                n_checks++;
                if (rgb !== BG) begin
                    n_fail++;
                    $display("FAIL no_wrap_col0: got %h expected %h", rgb, BG);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 10; k++) begin
                int c, r, d;
                c = $urandom_range(0, N - 1);
                r = $urandom_range(0, 2);
                d = (r == 0) ? $urandom_range(0, 1279) :
                    (r == 1) ? $urandom_range(0, 470) : $urandom_range(0, 7);
                bus_write(c * 4 + r, d, $urandom_range(0, 1279), $urandom_range(0, 479), 1);
            end
            for (int k = 0; k < 4; k++) bus_read($urandom_range(0, N * 4 - 1), 0, 520, 0, got);
            bus_read(511, 0, 520, 0, got);
            commit_frame();
            for (int l = 0; l < 5; l++) begin
                int c, v, h0, h1;
                c  = $urandom_range(0, N - 1);
                v  = m_ay[c] + $urandom_range(0, 31);
                if (v > 479) v = 479;
                h0 = m_ax[c] - 4;
                if (h0 < 0) h0 = 0;
                h1 = (h0 + 40 > 1295) ? 1295 : h0 + 40;
                draw_line(v, h0, h1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] got;
        bus_write(0, 150, 0, 520, 0);
        bus_write(1, 100, 0, 520, 0);
        bus_write(2, 1, 0, 520, 0);
        commit_frame();
        draw_line(100, 146, 160);
        bus_read(0, 150, 100, 1, got);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (rgb !== 24'd0 || blank_n_out !== 1'b0 || readdata !== 32'd0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got rgb=%h blank=%b rd=%h addr=%h expected all 0",
                     rgb, blank_n_out, readdata, rom_addr);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(150, 100, 1);
        cycle(151, 100, 1);
        cycle(152, 100, 1);
        n_checks++;
        if (rgb !== BG) begin
            n_fail++;
            $display("FAIL post_reset_bg: got %h expected %h", rgb, BG);
        end
        commit_frame();
        draw_line(100, 146, 160);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fill_rom();
        test_reset();
        test_basic();
        test_shadow_commit();
        test_unmapped();
        test_priority();
        test_collision();
        test_right_edge();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
